// File: rtl/lt24_pkg.sv
// rtl/lt24_pkg.sv - shared constants, state encoding and word ROM for the LT24 pixel writer
package lt24_pkg;

    localparam int LCD_WIDTH  = 240;
    localparam int LCD_HEIGHT = 320;

    localparam logic [7:0] CMD_COLADDR  = 8'h2A;
    localparam logic [7:0] CMD_PAGEADDR = 8'h2B;
    localparam logic [7:0] CMD_MEMWRITE = 8'h2C;

    localparam logic [3:0] LAST_WORD = 4'd11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_LOW  = 2'd1,
        WR_HIGH = 2'd2
    } state_t;

    typedef struct packed {
        logic        rs;
        logic [15:0] data;
    } lt24_word_t;

    // Column window is x..239, page window is y..319; the memory write follows
    function automatic lt24_word_t word_rom(input logic [3:0] idx, input logic [7:0] x,
                                            input logic [8:0] y, input logic [15:0] pix);
        lt24_word_t w;
        case (idx)
            4'd0:    w = '{rs: 1'b0, data: {8'h00, CMD_COLADDR}};
            4'd1:    w = '{rs: 1'b1, data: 16'h0000};
            4'd2:    w = '{rs: 1'b1, data: {8'h00, x}};
            4'd3:    w = '{rs: 1'b1, data: 16'h0000};
            4'd4:    w = '{rs: 1'b1, data: 16'h00EF};
            4'd5:    w = '{rs: 1'b0, data: {8'h00, CMD_PAGEADDR}};
            4'd6:    w = '{rs: 1'b1, data: {15'b0, y[8]}};
            4'd7:    w = '{rs: 1'b1, data: {8'h00, y[7:0]}};
            4'd8:    w = '{rs: 1'b1, data: 16'h0001};
            4'd9:    w = '{rs: 1'b1, data: 16'h003F};
            4'd10:   w = '{rs: 1'b0, data: {8'h00, CMD_MEMWRITE}};
            default: w = '{rs: 1'b1, data: pix};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lt24_bus_strobe.sv
// rtl/lt24_bus_strobe.sv - one 8080 write cycle per start; chains words without idle gaps
module lt24_bus_strobe
    import lt24_pkg::*;
#(
    parameter int WR_LOW_CYCLES  = 2,
    parameter int WR_HIGH_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        rs,
    input  logic [15:0] data,
    output state_t      state,
    output logic        done,
    output logic        wr_n,
    output logic        cs_n,
    output logic        bus_rs,
    output logic [15:0] bus_data
);

    localparam logic [3:0] LOW_LAST  = 4'(WR_LOW_CYCLES - 1);
    localparam logic [3:0] HIGH_LAST = 4'(WR_HIGH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_n_q, wr_n_d;
    logic        cs_n_q, cs_n_d;
    logic        rs_q, rs_d;
    logic [15:0] data_q, data_d;
    logic        load;

    assign done = (state_q == WR_HIGH) && (cnt_q == HIGH_LAST);
    // A start in the last high cycle loads the next word on the same edge
    assign load = start && ((state_q == IDLE) || done);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_n_d  = wr_n_q;
        cs_n_d  = cs_n_q;
        rs_d    = rs_q;
        data_d  = data_q;
        case (state_q)
            IDLE: ;
            WR_LOW: begin
                if (cnt_q == LOW_LAST) begin
                    state_d = WR_HIGH;
                    cnt_d   = 4'd0;
                    wr_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WR_HIGH: begin
                if (done) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    cs_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d = WR_LOW;
            cnt_d   = 4'd0;
            wr_n_d  = 1'b0;
            cs_n_d  = 1'b0;
            rs_d    = rs;
            data_d  = data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_n_q  <= 1'b1;
            cs_n_q  <= 1'b1;
            rs_q    <= 1'b1;
            data_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_n_q  <= wr_n_d;
            cs_n_q  <= cs_n_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

    assign state    = state_q;
    assign wr_n     = wr_n_q;
    assign cs_n     = cs_n_q;
    assign bus_rs   = rs_q;
    assign bus_data = data_q;

endmodule

// File: rtl/lt24_pixel_writer.sv
// rtl/lt24_pixel_writer.sv - accepts pixel requests and emits the 12-word LT24 window/write sequence
module lt24_pixel_writer
    import lt24_pkg::*;
#(
    parameter int CLOCK_FREQ     = 50000000,
    parameter int WR_LOW_CYCLES  = 2,
    parameter int WR_HIGH_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        initDone,
    input  logic [7:0]  xAddr,
    input  logic [8:0]  yAddr,
    input  logic [15:0] pixelData,
    input  logic        pixelWrite,
    output logic        ready,
    output logic        LT24_CS_n,
    output logic        LT24_RS,
    output logic        LT24_WR_n,
    output logic        LT24_RD_n,
    output logic [15:0] LT24_D
);

    if (CLOCK_FREQ < 1 || WR_LOW_CYCLES < 1 || WR_LOW_CYCLES > 15 ||
        WR_HIGH_CYCLES < 1 || WR_HIGH_CYCLES > 15) begin : g_bad_param
        $error("lt24_pixel_writer: parameter out of range");
    end

    localparam logic [7:0] X_LIMIT = 8'(LCD_WIDTH);
    localparam logic [8:0] Y_LIMIT = 9'(LCD_HEIGHT);

    state_t      state;
    logic        done;
    logic        accept;
    logic        in_range;
    logic        start;
    logic [3:0]  index;
    logic [7:0]  x_q;
    logic [8:0]  y_q;
    logic [15:0] pix_q;
    lt24_word_t  next_word;

    assign ready    = (state == IDLE) && initDone && !reset;
    assign accept   = pixelWrite && ready;
    assign in_range = (xAddr < X_LIMIT) && (yAddr < Y_LIMIT);
    assign start    = (accept && in_range) || (done && (index != LAST_WORD));

    // Word 0 is a constant command, so the unlatched inputs are safe on the accept edge
    assign next_word = accept ? word_rom(4'd0, xAddr, yAddr, pixelData)
                              : word_rom(index + 4'd1, x_q, y_q, pix_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            index <= 4'd0;
            x_q   <= 8'h00;
            y_q   <= 9'h000;
            pix_q <= 16'h0000;
        end else if (accept && in_range) begin
            index <= 4'd0;
            x_q   <= xAddr;
            y_q   <= yAddr;
            pix_q <= pixelData;
        end else if (done && (index != LAST_WORD)) begin
            index <= index + 4'd1;
        end
    end

    lt24_bus_strobe #(
        .WR_LOW_CYCLES (WR_LOW_CYCLES),
        .WR_HIGH_CYCLES(WR_HIGH_CYCLES)
    ) u_strobe (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .rs      (next_word.rs),
        .data    (next_word.data),
        .state   (state),
        .done    (done),
        .wr_n    (LT24_WR_n),
        .cs_n    (LT24_CS_n),
        .bus_rs  (LT24_RS),
        .bus_data(LT24_D)
    );

    assign LT24_RD_n = 1'b1;

endmodule

// File: doc/lt24_pixel_writer.md
Name: lt24_pixel_writer

Overview:
- Responder for single-pixel write requests from drawing engines (square, line, text).
- Accepts one (x, y, colour) request per handshake.
- Drives the DE1-SoC LT24 (ILI9341) 8080-style 16-bit parallel bus with a fixed 12-word sequence: column window, page window, memory write.
- Sits between the drawing engines and the LT24 pins. Panel power-up initialisation is done by a separate block, which signals completion on initDone.

Parameters:
- CLOCK_FREQ, 50000000, system clock in Hz; documentation only, no logic depends on it.
- WR_LOW_CYCLES, 2, clock cycles LT24_WR_n is held low per bus word (valid range 1..15).
- WR_HIGH_CYCLES, 2, clock cycles LT24_WR_n is held high per bus word (valid range 1..15).

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- initDone  input  1  panel initialised; level, held high once set.
- xAddr  input  8  pixel column, 0..239.
- yAddr  input  9  pixel row, 0..319.
- pixelData  input  16  RGB565 colour.
- pixelWrite  input  1  request strobe; accepted when pixelWrite && ready.
- ready  output  1  high when idle and able to accept a request.
- LT24_CS_n  output  1  chip select, active low.
- LT24_RS  output  1  0 = command word, 1 = data word.
- LT24_WR_n  output  1  write strobe; panel samples on the rising edge.
- LT24_RD_n  output  1  tied high (no reads).
- LT24_D  output  16  bus data.

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is asynchronous and active-high.
- Reset values: ready=0, LT24_CS_n=1, LT24_RS=1, LT24_WR_n=1, LT24_RD_n=1, LT24_D=0, state=IDLE, word index=0, counters=0.
- Reset mid-sequence: aborts immediately to the reset values above. The panel is not resynchronised; the next request restarts the sequence with a command word.
- States:
  - IDLE: ready = initDone.
  - WR_LOW: LT24_WR_n=0 for WR_LOW_CYCLES cycles.
  - WR_HIGH: LT24_WR_n=1 for WR_HIGH_CYCLES cycles.
- Acceptance:
  - At the accepting edge, xAddr, yAddr and pixelData are latched, word index is set to 0, and the state goes to WR_LOW.
  - ready falls in the following cycle.
  - Inputs may change freely after acceptance.
- Out-of-range requests: if xAddr>239 or yAddr>319, the request is accepted but dropped. No bus activity, state stays IDLE, ready stays high.
- Word sequence (index: RS, D):
  - 0: 0, 0x002A
  - 1: 1, 0x0000
  - 2: 1, {8'h00, x}
  - 3: 1, 0x0000
  - 4: 1, 0x00EF
  - 5: 0, 0x002B
  - 6: 1, {15'b0, y[8]}
  - 7: 1, {8'h00, y[7:0]}
  - 8: 1, 0x0001
  - 9: 1, 0x003F
  - 10: 0, 0x002C
  - 11: 1, pixelData
- Bus timing per word:
  - LT24_RS and LT24_D update on the same edge that enters WR_LOW.
  - Both stay stable through the whole WR_HIGH phase.
- Chip select: LT24_CS_n is low from the first WR_LOW cycle through the last WR_HIGH cycle of word 11, and high at all other times.
- Completion: on leaving the WR_HIGH phase of word 11, the state returns to IDLE, and ready and CS_n return high on the same edge.
- Cycle count: ready is low for exactly 12*(WR_LOW_CYCLES+WR_HIGH_CYCLES) cycles, which is 48 at the defaults.
- Back-to-back requests: a request presented on the first ready-high cycle is accepted. Sustained throughput at defaults is one pixel per 49 cycles.
- Requests while busy: pixelWrite while ready=0 is ignored and not queued.
- initDone low: ready=0 and no acceptance. A deassertion mid-sequence does not abort the sequence.

Decomposition:
- Shared package lt24_pkg:
  - LCD_WIDTH=240, LCD_HEIGHT=320.
  - Command codes CMD_COLADDR=0x2A, CMD_PAGEADDR=0x2B, CMD_MEMWRITE=0x2C.
  - State encodings.
- One sub-module, lt24_bus_strobe:
  - Given start, rs and data, it generates one WR_n low/high cycle and pulses done.
  - The parent holds the word index and the sequence ROM mux.

Test Plan:
1. Reset and init gating: reset high, then low with initDone=0 → ready=0 and all bus controls idle-high. Raise initDone → ready=1 in the next cycle.
2. Single write (x=10, y=300, pixelData=0xF800) → exactly 12 WR_n falling edges with RS/D sequence 0/0x2A, 1/0x00, 1/0x0A, 1/0x00, 1/0xEF, 0/0x2B, 1/0x01, 1/0x2C, 1/0x01, 1/0x3F, 0/0x2C, 1/0xF800. CS_n low throughout, ready low for 48 cycles.
3. Out of range (x=240, y=0) and (x=0, y=320) → no WR_n edge, CS_n stays high, ready stays 1.
4. Back-to-back: second request held from the first ready-high cycle → accepted immediately, 96 cycles total, 24 WR_n edges, CS_n pulses high for exactly 1 cycle between the two sequences.
5. pixelWrite pulsed while busy → ignored; exactly 12 words observed.
6. Reset asserted during word 6 → all outputs return to reset values asynchronously. A new request afterwards produces a full 12-word sequence starting with 0x2A.
